jtpopeye_dma_ctrl: RTL and testbench

Sequences the object-RAM DMA on the main board. On each start trigger (frame-end strobe) it requests the Z80 bus and waits for the grant. It then sweeps the upper 1 kB of main RAM through the DMA read port and writes each byte into the object buffer. Finally it releases the bus. It sits between the main CPU block (busrq_n/busak_n, dma_cs, AD_DMA, DD_DMA) and the video object buffer.

---
 rtl/jtpopeye_dma_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_jtpopeye_dma_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_dma_ctrl.sv
// jtpopeye_dma_ctrl: object-RAM DMA sequencer for the main board.
//
// On each rising edge of start the block requests the Z80 bus and waits
// for the grant. It then sweeps the upper 1 kB of main RAM through the DMA
// read port, writes every byte into the object buffer, and releases the bus.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   cpu_cen        CPU clock enable; busrq_n only changes on these cycles
//   start          transfer trigger (level, rising edge detected on clk)
//   busak_n        Z80 bus acknowledge (active low)
//   busrq_n        Z80 bus request (active low)
//   dma_cs         routes AD_DMA to main RAM
//   AD_DMA         DMA read address
//   DD_DMA         DMA read data, valid RD_LAT clk after AD_DMA/dma_cs
//   obj_we/obj_addr/obj_data  object buffer write port, one byte per clk
//   busy           high from accepted trigger until the bus is released
//   done           one-clk pulse at the end of a normal transfer
//   err            sticky abort flag, cleared by the next accepted trigger
//
// Optional build macro
//   JTPOPEYE_DMA_TIMEOUT_EN  give up the bus request after TO_MAX clk
//                            without a grant (sets err, no done pulse)

module jtpopeye_dma_ctrl #(
    parameter int unsigned LEN    = 1024,
    parameter int unsigned RD_LAT = 2
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    ,
    parameter int unsigned TO_MAX = 255
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_cen,
    input  logic       start,
    input  logic       busak_n,
    output logic       busrq_n,
    output logic       dma_cs,
    output logic [9:0] AD_DMA,
    input  logic [7:0] DD_DMA,
    output logic       obj_we,
    output logic [9:0] obj_addr,
    output logic [7:0] obj_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    localparam int unsigned TW = (TO_MAX > 1) ? $clog2(TO_MAX + 1) : 1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DRAIN,
        ST_REL
    } state_t;

    state_t                      state_q, state_d;
    logic                        start_l_q, start_l_d;
    logic                        pending_q, pending_d;
    logic                        busrq_n_q, busrq_n_d;
    logic                        dma_cs_q, dma_cs_d;
    logic [AW-1:0]               ad_q, ad_d;
    logic [CW-1:0]               drain_q, drain_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic                        obj_we_q, obj_we_d;
    logic [AW-1:0]               obj_addr_q, obj_addr_d;
    logic [DW-1:0]               obj_data_q, obj_data_d;
    logic [RD_LAT-1:0]           pipe_v_q, pipe_v_d;
    logic [RD_LAT-1:0][AW-1:0]   pipe_a_q, pipe_a_d;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    logic [TW-1:0]               to_cnt_q, to_cnt_d;
`endif

    logic trig;
    logic issue;
    logic abort;

    assign trig = start & ~start_l_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            start_l_q  <= 1'b0;
            pending_q  <= 1'b0;
            busrq_n_q  <= 1'b1;
            dma_cs_q   <= 1'b0;
            ad_q       <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            obj_we_q   <= 1'b0;
            obj_addr_q <= '0;
            obj_data_q <= '0;
            pipe_v_q   <= '0;
            pipe_a_q   <= '0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            start_l_q  <= start_l_d;
            pending_q  <= pending_d;
            busrq_n_q  <= busrq_n_d;
            dma_cs_q   <= dma_cs_d;
            ad_q       <= ad_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            obj_we_q   <= obj_we_d;
            obj_addr_q <= obj_addr_d;
            obj_data_q <= obj_data_d;
            pipe_v_q   <= pipe_v_d;
            pipe_a_q   <= pipe_a_d;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    // Next-state, bus handshake and write pipeline
    always_comb begin
        state_d    = state_q;
        start_l_d  = start;
        pending_d  = pending_q;
        busrq_n_d  = busrq_n_q;
        dma_cs_d   = dma_cs_q;
        ad_d       = ad_q;
        drain_d    = drain_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        obj_we_d   = 1'b0;
        obj_addr_d = obj_addr_q;
        obj_data_d = obj_data_q;
        pipe_v_d   = '0;
        pipe_a_d   = pipe_a_q;
        issue      = 1'b0;
        abort      = 1'b0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif

        // A trigger arriving while a transfer is in progress is held (depth 1)
        if (trig && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_REQ;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end

            ST_REQ: begin
                if (cpu_cen) begin
                    busrq_n_d = 1'b0;
                end
                if (!busrq_n_q && !busak_n) begin
                    state_d  = ST_XFER;
                    dma_cs_d = 1'b1;
                    ad_d     = '0;
                end
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
                else if (to_cnt_q == TW'(TO_MAX)) begin
                    // No grant in time: abort and let REL drop the request
                    err_d   = 1'b1;
                    state_d = ST_REL;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
`endif
            end

            ST_XFER: begin
                if (busak_n) begin
                    abort = 1'b1;
                end else begin
                    issue = 1'b1;
                    if (ad_q == AW'(LEN - 1)) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        ad_d = ad_q + AW'(1);
                    end
                end
            end

            ST_DRAIN: begin
                // Keep the RAM routed until the last RD_LAT reads return
                if (busak_n) begin
                    abort = 1'b1;
                end else if (drain_q == CW'(RD_LAT - 1)) begin
                    state_d  = ST_REL;
                    dma_cs_d = 1'b0;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end

            ST_REL: begin
                dma_cs_d = 1'b0;
                if (cpu_cen) begin
                    busrq_n_d = 1'b1;
                end
                if (busrq_n_q && busak_n) begin
                    done_d = ~err_q;
                    if (pending_q || trig) begin
                        // Back-to-back transfer: busy stays high
                        pending_d = 1'b0;
                        err_d     = 1'b0;
                        state_d   = ST_REQ;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
                        to_cnt_d  = '0;
`endif
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Grant lost: drop the bus side and discard everything in flight
        if (abort) begin
            err_d    = 1'b1;
            dma_cs_d = 1'b0;
            state_d  = ST_REL;
        end

        // Read-latency delay line carrying {valid, addr}
        pipe_v_d[0] = issue;
        pipe_a_d[0] = ad_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_a_d[i] = pipe_a_q[i-1];
        end
        if (abort) begin
            pipe_v_d = '0;
        end

        if (pipe_v_q[RD_LAT-1] && !abort) begin
            obj_we_d   = 1'b1;
            obj_addr_d = pipe_a_q[RD_LAT-1];
            obj_data_d = DD_DMA;
        end
    end

    assign busrq_n  = busrq_n_q;
    assign dma_cs   = dma_cs_q;
    assign AD_DMA   = ad_q;
    assign obj_we   = obj_we_q;
    assign obj_addr = obj_addr_q;
    assign obj_data = obj_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_jtpopeye_dma_ctrl.sv
// Testbench for jtpopeye_dma_ctrl: table of transfer scenarios plus
// hand-written reset-abort and grant-timeout sequences.
module tb_jtpopeye_dma_ctrl;

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    localparam int TO_MAX = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_cen = 1'b0;
    logic       start = 1'b0;
    logic       busak_n;
    logic       busrq_n;
    logic       dma_cs;
    logic [9:0] AD_DMA;
    logic [7:0] DD_DMA = 8'h00;
    logic       obj_we;
    logic [9:0] obj_addr;
    logic [7:0] obj_data;
    logic       busy;
    logic       done;
    logic       err;

    jtpopeye_dma_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_cen  (cpu_cen),
        .start    (start),
        .busak_n  (busak_n),
        .busrq_n  (busrq_n),
        .dma_cs   (dma_cs),
        .AD_DMA   (AD_DMA),
        .DD_DMA   (DD_DMA),
        .obj_we   (obj_we),
        .obj_addr (obj_addr),
        .obj_data (obj_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial forever #5 clk = ~clk;

    // CPU clock enable: one cycle in cen_per
    int cen_per = 1;
    int cen_cnt = 0;
    initial forever begin
        @(posedge clk); #1;
        cen_cnt = (cen_cnt + 1) % cen_per;
        cpu_cen = (cen_cnt == 0);
    end

    // Z80 bus arbiter: grants gdly cycles after busrq_n falls
    int   gdly = 3;
    int   gcnt = 0;
    bit   resp_en = 1'b1;
    bit   force_rel = 1'b0;
    logic gnt_q = 1'b0;
    initial forever begin
        @(posedge clk); #1;
        if (!resp_en || busrq_n) begin
            gnt_q = 1'b0;
            gcnt  = 0;
        end else if (gcnt >= gdly) begin
            gnt_q = 1'b1;
        end else begin
            gcnt++;
        end
    end
    assign busak_n = ~(gnt_q & ~force_rel);

    // Main RAM model, 2 clk read latency, data = addr[7:0] ^ 5A
    logic [7:0] ram_d1 = 8'h00;
    always @(posedge clk) begin
        ram_d1 <= AD_DMA[7:0] ^ 8'h5A;
        DD_DMA <= ram_d1;
    end

    // Write/handshake monitor: accumulates statistics checked by the main thread
    int         wr_cnt = 0, done_cnt = 0, gap_cnt = 0, bad_cnt = 0, bad_rq = 0;
    logic [9:0] exp_a = 10'd0;
    logic       prev_we = 1'b0, prev_cs = 1'b0, prev_rq = 1'b1, prev_cen = 1'b0, prev_rst = 1'b0;
    initial forever begin
        @(negedge clk);
        if (dma_cs && !prev_cs) exp_a = 10'd0;
        if (obj_we) begin
            wr_cnt++;
            if (obj_addr !== exp_a || obj_data !== (exp_a[7:0] ^ 8'h5A)) bad_cnt++;
            exp_a = exp_a + 10'd1;
        end
        if (rst_n && prev_we && !obj_we && exp_a != 10'd0 && !err) gap_cnt++;
        if (rst_n && prev_rst && (busrq_n !== prev_rq) && !prev_cen) bad_rq++;
        if (done) done_cnt++;
        prev_we  = rst_n ? obj_we : 1'b0;
        prev_cs  = dma_cs;
        prev_rq  = busrq_n;
        prev_cen = cpu_cen;
        prev_rst = rst_n;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    typedef struct {
        int cen;      // cpu_cen period
        int gd;       // grant delay
        int abort_at; // byte count at which the grant is pulled (-1 none)
        int x1;       // extra trigger at byte count (-1 none)
        int x2;
        int exp_wr;
        int exp_done;
        int exp_err;
    } scen_t;

    scen_t tbl[6];

    task automatic run_scen(input int i);
        scen_t s;
        int    w0, d0, g0, b0, r0;
        int    cyc;
        bit    f1, f2, fa;
        s = tbl[i];
        cyc = 0; f1 = 1'b0; f2 = 1'b0; fa = 1'b0;
        cen_per = s.cen;
        gdly    = s.gd;
        w0 = wr_cnt; d0 = done_cnt; g0 = gap_cnt; b0 = bad_cnt; r0 = bad_rq;
        pulse_start();
        chk($sformatf("s%0d_busy_on", i), busy, 1);
        chk($sformatf("s%0d_err_clr", i), err, 0);
        while (busy === 1'b1 && cyc < 12000) begin
            @(negedge clk); #1;
            cyc++;
            if (start) start = 1'b0;
            else if (s.x1 >= 0 && !f1 && (wr_cnt - w0) >= s.x1) begin start = 1'b1; f1 = 1'b1; end
            else if (s.x2 >= 0 && !f2 && (wr_cnt - w0) >= s.x2) begin start = 1'b1; f2 = 1'b1; end
            if (s.abort_at >= 0 && !fa && (wr_cnt - w0) >= s.abort_at) begin
                force_rel = 1'b1;
                fa = 1'b1;
                @(negedge clk); #1;
                cyc++;
                chk($sformatf("s%0d_abort_we", i), obj_we, 0);
                chk($sformatf("s%0d_abort_cs", i), dma_cs, 0);
                chk($sformatf("s%0d_abort_err", i), err, 1);
                chk($sformatf("s%0d_abort_cnt", i), wr_cnt - w0, s.abort_at);
            end
        end
        start = 1'b0;
        chk($sformatf("s%0d_no_timeout", i), cyc < 12000, 1);
        repeat (10) @(negedge clk);
        #1;
        chk($sformatf("s%0d_writes", i), wr_cnt - w0, s.exp_wr);
        chk($sformatf("s%0d_dones", i), done_cnt - d0, s.exp_done);
        chk($sformatf("s%0d_err", i), err, s.exp_err);
        chk($sformatf("s%0d_data", i), bad_cnt - b0, 0);
        chk($sformatf("s%0d_gaps", i), gap_cnt - g0, 0);
        chk($sformatf("s%0d_rq_on_cen", i), bad_rq - r0, 0);
        chk($sformatf("s%0d_busrq_n", i), busrq_n, 1);
        chk($sformatf("s%0d_dma_cs", i), dma_cs, 0);
        chk($sformatf("s%0d_busy_off", i), busy, 0);
        force_rel = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int w0, d0, cyc, hi;
        //           cen gd  abort  x1    x2   wr    done err
        tbl[0] = '{1, 3, -1,   -1,   -1,  1024, 1, 0};
        tbl[1] = '{1, 3, -1,   500,  600, 2048, 2, 0};
        tbl[2] = '{1, 3, 300,  -1,   -1,  300,  0, 1};
        tbl[3] = '{1, 1, -1,   -1,   -1,  1024, 1, 0};
        tbl[4] = '{4, 3, -1,   -1,   -1,  1024, 1, 0};
        tbl[5] = '{4, 2, -1,   1000, -1,  2048, 2, 0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busrq_n", busrq_n, 1);
        chk("rst_dma_cs", dma_cs, 0);
        chk("rst_ad", AD_DMA, 0);
        chk("rst_obj_we", obj_we, 0);
        chk("rst_obj_addr", obj_addr, 0);
        chk("rst_obj_data", obj_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) run_scen(i);

        // Asynchronous reset in the middle of a transfer
        cen_per = 1;
        gdly    = 3;
        w0  = wr_cnt;
        cyc = 0;
        pulse_start();
        while ((wr_cnt - w0) < 100 && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("rstmid_reach", cyc < 2000, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busrq_n", busrq_n, 1);
        chk("rstmid_obj_we", obj_we, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_dma_cs", dma_cs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_cnt;
        d0 = done_cnt;
        repeat (50) @(negedge clk);
        #1;
        chk("rstmid_quiet_wr", wr_cnt - w0, 0);
        chk("rstmid_quiet_done", done_cnt - d0, 0);
        chk("rstmid_quiet_rq", busrq_n, 1);
        chk("rstmid_quiet_busy", busy, 0);
        run_scen(0);

        // Grant never arrives
        resp_en = 1'b0;
        cen_per = 4;
        d0  = done_cnt;
        cyc = 0;
        pulse_start();
        while (busrq_n === 1'b1 && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("nogrant_rq_fell", busrq_n, 0);
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
        cyc = 0;
        while (!(busrq_n === 1'b1 && err === 1'b1) && cyc < 400) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("to_err", err, 1);
        chk("to_rel", busrq_n, 1);
        chk("to_not_late", cyc <= TO_MAX + 12, 1);
        chk("to_not_early", cyc >= TO_MAX - 8, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("to_busy_off", busy, 0);
        chk("to_no_done", done_cnt - d0, 0);
`else
        hi = 0;
        repeat (10000) begin
            @(negedge clk); #1;
            if (busrq_n !== 1'b0) hi++;
        end
        chk("wait_rq_held", hi, 0);
        chk("wait_busy", busy, 1);
        chk("wait_err", err, 0);
        chk("wait_no_done", done_cnt - d0, 0);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
